// File: rtl/input_feeder_pkg.sv
// Shared defaults and the feeder state encoding for the input-side blocks.
package input_feeder_pkg;

   localparam int unsigned BIN_LEN       = 8;
   localparam int unsigned INPUT_WIDTH   = 3;
   localparam int unsigned INPUT_HEIGHT  = 2;
   localparam int unsigned IN_ADDR_WIDTH = 8;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_FULL  = 3'd3,
      S_DONE  = 3'd4
   } feeder_state_e;

endpackage

// File: rtl/input_feeder_if.sv
// Consumer handshake plus SRAM read port of the input feeder.
interface input_feeder_if #(
   parameter int unsigned BIN_LEN    = input_feeder_pkg::BIN_LEN,
   parameter int unsigned ADDR_WIDTH = input_feeder_pkg::IN_ADDR_WIDTH
);

   logic                  input_req;
   logic [BIN_LEN-1:0]    input_val;
   logic                  input_ready;
   logic                  mem_rd_en;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [BIN_LEN-1:0]    mem_rdata;

   // Feeder side
   modport slave (
      input  input_req, mem_rdata,
      output input_val, input_ready, mem_rd_en, mem_addr
   );

   // Environment side: consumer and SRAM
   modport master (
      output input_req, mem_rdata,
      input  input_val, input_ready, mem_rd_en, mem_addr
   );

endinterface

// File: rtl/input_feeder_raster_addr_gen.sv
// Raster element counter and SRAM read-address generator for one feature map.
module input_feeder_raster_addr_gen #(
   parameter int unsigned N          = 6,
   parameter int unsigned CNT_W      = 3,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned BASE_ADDR  = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_clear,
   input  logic                  i_inc,
   output logic                  o_last,
   output logic [ADDR_WIDTH-1:0] o_addr
);

   logic [CNT_W-1:0]      r_count;
   logic [ADDR_WIDTH-1:0] r_addr;

   // Count and address advance together so the address never needs an adder on the output
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_count <= '0;
         r_addr  <= '0;
      end else if (i_clear) begin
         r_count <= '0;
         r_addr  <= ADDR_WIDTH'(BASE_ADDR);
      end else if (i_inc) begin
         r_count <= r_count + CNT_W'(1);
         r_addr  <= r_addr + ADDR_WIDTH'(1);
      end
   end

   assign o_last = (r_count == CNT_W'(N - 1));
   assign o_addr = r_addr;

endmodule

// File: rtl/input_feeder.sv
// Streams one feature map from input SRAM to the processing unit through a one-word prefetch buffer.
module input_feeder #(
   parameter int unsigned BIN_LEN      = input_feeder_pkg::BIN_LEN,
   parameter int unsigned INPUT_WIDTH  = input_feeder_pkg::INPUT_WIDTH,
   parameter int unsigned INPUT_HEIGHT = input_feeder_pkg::INPUT_HEIGHT,
   parameter int unsigned ADDR_WIDTH   = input_feeder_pkg::IN_ADDR_WIDTH,
   parameter int unsigned BASE_ADDR    = 0
) (
   input  logic           i_clock,
   input  logic           i_reset,
   input  logic           i_start,
   input_feeder_if.slave  io,
   output logic           o_busy,
   output logic           o_done
);

   import input_feeder_pkg::*;

   localparam int unsigned N     = INPUT_WIDTH * INPUT_HEIGHT;
   localparam int unsigned CNT_W = $clog2(N + 1);

   feeder_state_e         r_state;
   feeder_state_e         w_next_state;
   logic [BIN_LEN-1:0]    r_buf;
   logic [BIN_LEN-1:0]    r_last_val;
   logic                  r_mem_rd_en;
   logic                  r_busy;
   logic                  r_done;
   logic                  w_clear;
   logic                  w_xfer;
   logic                  w_last;
   logic [ADDR_WIDTH-1:0] w_addr;

   input_feeder_raster_addr_gen #(
      .N          (N),
      .CNT_W      (CNT_W),
      .ADDR_WIDTH (ADDR_WIDTH),
      .BASE_ADDR  (BASE_ADDR)
   ) u_addr_gen (
      .i_clk   (i_clock),
      .i_rst_n (i_reset),
      .i_clear (w_clear),
      .i_inc   (w_xfer),
      .o_last  (w_last),
      .o_addr  (w_addr)
   );

   // Next-state logic; a transfer happens in FULL in the same cycle the request is seen
   always_comb begin
      w_next_state = r_state;
      w_clear      = 1'b0;
      w_xfer       = 1'b0;
      unique case (r_state)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               w_next_state = S_FETCH;
               w_clear      = 1'b1;
            end
         end
         S_FETCH: w_next_state = S_WAIT;
         S_WAIT:  w_next_state = S_FULL;
         S_FULL: begin
            if (io.input_req) begin
               w_xfer       = 1'b1;
               w_next_state = w_last ? S_DONE : S_FETCH;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // State register with status/strobe outputs registered against the next state
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_state     <= S_IDLE;
         r_mem_rd_en <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_mem_rd_en <= (w_next_state == S_FETCH);
         r_busy      <= (w_next_state inside {S_FETCH, S_WAIT, S_FULL});
         r_done      <= (w_next_state == S_DONE);
      end
   end

   // Prefetch buffer loads SRAM data in WAIT; last-transferred word is kept for the idle value
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_buf      <= '0;
         r_last_val <= '0;
      end else begin
         if (r_state == S_WAIT) r_buf <= io.mem_rdata;
         if (w_xfer)            r_last_val <= r_buf;
      end
   end

   assign io.input_ready = w_xfer;
   assign io.input_val   = w_xfer ? r_buf : r_last_val;
   assign io.mem_rd_en   = r_mem_rd_en;
   assign io.mem_addr    = w_addr;
   assign o_busy         = r_busy;
   assign o_done         = r_done;

endmodule
